// File: rtl/chorus_sweep_ctrl_if.sv
// Codec-side and buffer-side signal bundle for the chorus sweep controller.
// The controller takes the slave view; whoever drives samples and reads the
// buffer controls takes the master view.
interface chorus_sweep_ctrl_if;
  logic        sampleValid;
  logic [15:0] rateDiv;
  logic        freeze;
  logic        clearOverrun;
  logic        enable;
  logic [15:0] delay;
  logic        outValid;
  logic        sweepDir;
  logic        overrun;

  modport master (
    output sampleValid, rateDiv, freeze, clearOverrun,
    input  enable, delay, outValid, sweepDir, overrun
  );

  modport slave (
    input  sampleValid, rateDiv, freeze, clearOverrun,
    output enable, delay, outValid, sweepDir, overrun
  );
endinterface

// File: rtl/chorus_sweep_ctrl.sv
// Chorus delay-line sequencer: turns each codec sample strobe into a one-cycle
// buffer enable followed by a one-cycle output-valid flag, and sweeps the
// buffer delay as a triangle LFO between MIN_DELAY and MAX_DELAY.
module chorus_sweep_ctrl #(
  parameter int unsigned MIN_DELAY   = 441,
  parameter int unsigned MAX_DELAY   = 1323,
  parameter int unsigned BUFFER_SIZE = 44100
) (
  input logic                clk,
  input logic                resetn,
  chorus_sweep_ctrl_if.slave bus
);

  // A zero minimum would make the buffer pass the dry signal; the upper bound
  // must fit both the buffer depth and the 16-bit delay port.
  if (MIN_DELAY < 1 || MIN_DELAY >= MAX_DELAY || MAX_DELAY >= BUFFER_SIZE ||
      MAX_DELAY > 65535) begin : g_bad_params
    $error("chorus_sweep_ctrl: need 1 <= MIN_DELAY < MAX_DELAY < BUFFER_SIZE");
  end

  localparam logic [15:0] MIN_D = 16'(MIN_DELAY);
  localparam logic [15:0] MAX_D = 16'(MAX_DELAY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic        enable_q;
  logic        out_valid_q;
  logic [15:0] delay_q;
  logic        sweep_dir_q;
  logic [15:0] step_cnt;
  logic        overrun_q;

  // Sequencer, overrun flag and LFO in one registered process.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge values and statement order only matters for overlapping writes
  // to the same register (used deliberately for the overrun set/clear).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      enable_q    <= 1'b0;
      out_valid_q <= 1'b0;
      delay_q     <= MIN_D;
      sweep_dir_q <= 1'b1;
      step_cnt    <= 16'd0;
      overrun_q   <= 1'b0;
    end else begin
      // The set is written last so it wins over a simultaneous clear.
      if (bus.clearOverrun) overrun_q <= 1'b0;
      if (bus.sampleValid && state != IDLE) overrun_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.sampleValid) begin
            state    <= ISSUE;
            enable_q <= 1'b1;
          end
        end

        ISSUE: begin
          state       <= DONE;
          enable_q    <= 1'b0;
          out_valid_q <= 1'b1;
          // One LFO tick per processed sample; the delay moves only here,
          // i.e. after the buffer has captured with the old value.
          if (!bus.freeze) begin
            if (bus.rateDiv == 16'd0) begin
              step_cnt <= 16'd0;
            end else if (step_cnt >= bus.rateDiv - 16'd1) begin
              step_cnt <= 16'd0;
              if (sweep_dir_q) begin
                if (delay_q >= MAX_D) begin
                  sweep_dir_q <= 1'b0;
                  delay_q     <= delay_q - 16'd1;
                end else begin
                  delay_q <= delay_q + 16'd1;
                end
              end else begin
                if (delay_q <= MIN_D) begin
                  sweep_dir_q <= 1'b1;
                  delay_q     <= delay_q + 16'd1;
                end else begin
                  delay_q <= delay_q - 16'd1;
                end
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          enable_q    <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered state drives the buffer ports directly.
  assign bus.enable   = enable_q;
  assign bus.outValid = out_valid_q;
  assign bus.delay    = delay_q;
  assign bus.sweepDir = sweep_dir_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_chorus_sweep_ctrl.sv
// Bench for chorus_sweep_ctrl with MIN_DELAY=4, MAX_DELAY=7, BUFFER_SIZE=16.
// Fixed sweep/freeze vectors from a table, hand sequences for overrun and
// async reset, then random traffic against a triangle-wave reference model.
module tb_chorus_sweep_ctrl;
  localparam int MIN_D  = 4;
  localparam int MAX_D  = 7;
  localparam int SPAN   = MAX_D - MIN_D;
  localparam int PERIOD = 2 * SPAN;

  typedef struct {
    int rate_div;
    bit freeze;
    int exp_delay;
    bit exp_dir;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  chorus_sweep_ctrl_if bus ();

  chorus_sweep_ctrl #(
    .MIN_DELAY  (MIN_D),
    .MAX_DELAY  (MAX_D),
    .BUFFER_SIZE(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int ov_cnt = 0;

  // Pulse counters, sampled as each edge closes the cycle.
  always @(posedge clk) begin
    if (bus.enable) en_cnt++;
    if (bus.outValid) ov_cnt++;
  end

  // Reference model: the sweep is a triangle indexed by the number of steps taken.
  int  m_steps;
  int  m_held;
  bit  m_ovr;

  function automatic int tri_delay(int p);
    int m;
    m = p % PERIOD;
    return MIN_D + ((m <= SPAN) ? m : PERIOD - m);
  endfunction

  function automatic bit tri_dir(int p);
    int m;
    if (p == 0) return 1'b1;
    m = p % PERIOD;
    return (m >= 1 && m <= SPAN);
  endfunction

  task automatic model_reset();
    m_steps = 0;
    m_held  = 0;
    m_ovr   = 1'b0;
  endtask

  // Each value is held for rate samples before the next step.
  task automatic model_sample(int rate, bit frz);
    if (frz) return;
    if (rate == 0) begin
      m_held = 0;
    end else begin
      m_held++;
      if (m_held >= rate) begin
        m_held = 0;
        m_steps++;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_delay", bus.delay, MIN_D);
    check("rst_dir", bus.sweepDir, 1);
    check("rst_enable", bus.enable, 0);
    check("rst_outvalid", bus.outValid, 0);
    check("rst_overrun", bus.overrun, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One sample strobe; extra=1/2 re-asserts sampleValid during ISSUE/DONE.
  task automatic send_sample(int extra);
    @(negedge clk);
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.sampleValid = (extra == 1);
    check("enable_e0", bus.enable, 1);
    check("outvalid_e0", bus.outValid, 0);
    @(negedge clk);
    bus.sampleValid = (extra == 2);
    check("enable_e1", bus.enable, 0);
    check("outvalid_e1", bus.outValid, 1);
    @(negedge clk);
    bus.sampleValid = 1'b0;
    check("enable_e2", bus.enable, 0);
    check("outvalid_e2", bus.outValid, 0);
  endtask

  vec_t vecs[22];

  initial begin
    int en0, ov0, rate, extra;
    bit frz;

    resetn           = 1'b0;
    bus.sampleValid  = 1'b0;
    bus.rateDiv      = 16'd0;
    bus.freeze       = 1'b0;
    bus.clearOverrun = 1'b0;

    // Sweep with rateDiv=2, then freeze for 4 samples, then rateDiv=0 for 4.
    vecs[0]  = '{2, 0, 4, 1};  vecs[1]  = '{2, 0, 5, 1};
    vecs[2]  = '{2, 0, 5, 1};  vecs[3]  = '{2, 0, 6, 1};
    vecs[4]  = '{2, 0, 6, 1};  vecs[5]  = '{2, 0, 7, 1};
    vecs[6]  = '{2, 0, 7, 1};  vecs[7]  = '{2, 0, 6, 0};
    vecs[8]  = '{2, 0, 6, 0};  vecs[9]  = '{2, 0, 5, 0};
    vecs[10] = '{2, 0, 5, 0};  vecs[11] = '{2, 0, 4, 0};
    vecs[12] = '{2, 0, 4, 0};  vecs[13] = '{2, 0, 5, 1};
    for (int i = 14; i < 18; i++) vecs[i] = '{2, 1, 5, 1};
    for (int i = 18; i < 22; i++) vecs[i] = '{0, 0, 5, 1};

    do_reset();

    // Single sample, then 20 quiet cycles.
    en0 = en_cnt;
    ov0 = ov_cnt;
    send_sample(0);
    repeat (20) @(negedge clk);
    check("single_enable_cnt", en_cnt - en0, 1);
    check("single_outvalid_cnt", ov_cnt - ov0, 1);
    check("single_delay_hold", bus.delay, MIN_D);

    // Table: sweep and freeze/hold, samples spaced 5 cycles apart.
    for (int i = 0; i < 22; i++) begin
      if (i == 14) en0 = en_cnt;
      bus.rateDiv = 16'(vecs[i].rate_div);
      bus.freeze  = vecs[i].freeze;
      send_sample(0);
      @(negedge clk);
      check($sformatf("vec%0d_delay", i), bus.delay, vecs[i].exp_delay);
      check($sformatf("vec%0d_dir", i), bus.sweepDir, vecs[i].exp_dir);
    end
    check("hold_enable_cnt", en_cnt - en0, 8);
    bus.freeze  = 1'b0;
    bus.rateDiv = 16'd0;

    // Overrun: second strobe one cycle after the first is dropped.
    en0 = en_cnt;
    send_sample(1);
    @(negedge clk);
    check("ovr_enable_cnt", en_cnt - en0, 1);
    check("ovr_set", bus.overrun, 1);
    bus.clearOverrun = 1'b1;
    @(negedge clk);
    bus.clearOverrun = 1'b0;
    check("ovr_clear", bus.overrun, 0);

    // Set wins over a simultaneous clear.
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.clearOverrun = 1'b1;
    @(negedge clk);
    bus.sampleValid  = 1'b0;
    bus.clearOverrun = 1'b0;
    check("ovr_set_wins", bus.overrun, 1);
    repeat (3) @(negedge clk);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int it = 0; it < 200; it++) begin
      rate  = $urandom_range(0, 3);
      frz   = ($urandom_range(0, 5) == 0);
      extra = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        bus.clearOverrun = 1'b1;
        @(negedge clk);
        bus.clearOverrun = 1'b0;
        m_ovr = 1'b0;
      end
      bus.rateDiv = 16'(rate);
      bus.freeze  = frz;
      en0 = en_cnt;
      send_sample(extra);
      @(negedge clk);
      model_sample(rate, frz);
      if (extra != 0) m_ovr = 1'b1;
      check("rnd_delay", bus.delay, tri_delay(m_steps));
      check("rnd_dir", bus.sweepDir, tri_dir(m_steps));
      check("rnd_overrun", bus.overrun, m_ovr);
      check("rnd_enable_cnt", en_cnt - en0, 1);
    end
    bus.freeze = 1'b0;

    // Async reset while in ISSUE aborts the pulse.
    bus.rateDiv = 16'd1;
    @(negedge clk);
    bus.sampleValid = 1'b1;
    @(negedge clk);
    bus.sampleValid = 1'b0;
    check("arst_enable_before", bus.enable, 1);
    ov0 = ov_cnt;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_enable", bus.enable, 0);
    check("arst_delay", bus.delay, MIN_D);
    check("arst_dir", bus.sweepDir, 1);
    check("arst_outvalid", bus.outValid, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_outvalid", ov_cnt - ov0, 0);
    check("arst_delay_after", bus.delay, MIN_D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chorus_sweep_ctrl.md
# chorus_sweep_ctrl

Sequencer and delay modulator for the chorus delay line. It turns the codec's per-sample strobe into a single-cycle buffer enable, then flags when the buffer's dry and delayed outputs are valid. It also sweeps the buffer's 16-bit delay input as a triangle LFO between two bounds. It sits between the audio codec interface and the circular delay buffer, and drives the buffer's `enable` and `delay` ports directly.

## Interface
- `MIN_DELAY`, default 441: lower sweep bound in samples (10 ms at 44.1 kHz). Must be ≥ 1; 0 would collapse the buffer to dry passthrough.
- `MAX_DELAY`, default 1323: upper sweep bound in samples (30 ms). Must satisfy MIN_DELAY < MAX_DELAY < BUFFER_SIZE.
- `BUFFER_SIZE`, default 44100: depth of the driven delay buffer. Used only for the parameter check.
- `clk` input 1: system clock. Single clock domain.
- `resetn` input 1: asynchronous, active-low reset.
- `sampleValid` input 1: one-cycle pulse from the codec; a new input sample is present on the buffer's data input.
- `rateDiv` input 16: number of processed samples per 1-sample delay step. 0 means hold the delay.
- `freeze` input 1: while high, the LFO (delay and step counter) holds. Sequencing continues.
- `clearOverrun` input 1: synchronous clear of `overrun`.
- `enable` output 1: one-cycle strobe to the buffer's `enable` port.
- `delay` output 16: delay to the buffer's `delay` port, in samples.
- `outValid` output 1: one-cycle pulse; buffer `dataOut1`/`dataOut2` are valid this cycle.
- `sweepDir` output 1: 1 = delay rising, 0 = falling.
- `overrun` output 1: sticky flag; a `sampleValid` arrived while busy.

## Operation
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: on `sampleValid`=1, go to ISSUE.
  - ISSUE: unconditionally go to DONE.
  - DONE: unconditionally go to IDLE.
- Outputs are registered and decoded from the state: `enable`=1 only in ISSUE; `outValid`=1 only in DONE.
- Busy rule: `sampleValid`=1 in ISSUE or DONE is dropped (no extra enable) and sets `overrun`=1.
  - If `clearOverrun` and a new overrun occur in the same cycle, `overrun` stays 1 (set wins).
- LFO update happens once per processed sample, on the ISSUE→DONE edge, when `freeze`=0 and `rateDiv`≠0:
  - If `stepCnt` ≥ `rateDiv`−1: `stepCnt`←0 and take a delay step. Otherwise `stepCnt`←`stepCnt`+1.
  - The ≥ comparison covers `rateDiv` being lowered mid-run.
- Delay step:
  - Rising (`sweepDir`=1): if `delay` ≥ MAX_DELAY, set `sweepDir`←0 and `delay`←`delay`−1; else `delay`←`delay`+1.
  - Falling (`sweepDir`=0): if `delay` ≤ MIN_DELAY, set `sweepDir`←1 and `delay`←`delay`+1; else `delay`←`delay`−1.
  - Result: `delay` never leaves [MIN_DELAY, MAX_DELAY]. Each endpoint is held for `rateDiv` samples, the same as interior values.
- `rateDiv`=0: `delay` and `sweepDir` hold, `stepCnt`←0.
- `freeze`=1: `delay`, `sweepDir` and `stepCnt` all hold.
- `stepCnt` is 16 bits, unsigned. All arithmetic is 16-bit unsigned; no wrap is reachable, given the bound check.

## Timing
- Reset values (asserted immediately, asynchronously): state=IDLE, `enable`=0, `outValid`=0, `delay`=MIN_DELAY, `sweepDir`=1, `stepCnt`=0, `overrun`=0.
- `sampleValid` is sampled high in IDLE at edge E0:
  - `enable`=1 for exactly the cycle E0→E1.
  - The buffer captures the sample at E1, using the `delay` value held during E0→E1.
  - `outValid`=1 for the cycle E1→E2. A new `delay` value is visible from E1.
  - The controller is back in IDLE after E2, so the minimum `sampleValid` spacing is 3 cycles.
- `delay` changes only at E1 edges, never while `enable` is high.
- Reset asserted mid-sequence: the pulse is aborted with no `outValid`, and the buffer sees `enable` fall immediately.

## Test plan
All tests use MIN_DELAY=4, MAX_DELAY=7, BUFFER_SIZE=16.
- Reset: pulse `resetn` low. Required: `delay`=4, `sweepDir`=1, `enable`=0, `outValid`=0, `overrun`=0.
- Single sample: one `sampleValid` pulse. Required: `enable` high for exactly 1 cycle starting 1 cycle later, then `outValid` high for exactly the next cycle. No further pulses over 20 idle cycles.
- Sweep: `rateDiv`=2, 14 samples spaced 5 cycles apart. Required `delay` after each sample: 4,5,5,6,6,7,7,6,6,5,5,4,4,5. `sweepDir` goes to 0 after sample 8 and back to 1 after sample 14.
- Overrun: `sampleValid` again 1 cycle after the first. Required: one `enable` pulse only, `overrun`=1. Then pulse `clearOverrun`. Required: `overrun`=0.
- Freeze and hold: `freeze`=1 for 4 samples, then `rateDiv`=0 for 4 samples. Required: `delay` constant throughout and `enable` pulses 8 times.
- Async reset: drop `resetn` mid-cycle while in ISSUE. Required: `enable`=0 before the next edge, `delay`=4, and no `outValid` follows.
